// File: rtl/output_port_demux_pkg.sv
// Shared types and defaults for the output port demux.
// FSM encoding, parameter defaults and the drop counter ceiling.
package output_port_demux_pkg;

  localparam int DEF_DATA_WIDTH   = 256;
  localparam int DEF_TUSER_WIDTH  = 128;
  localparam int DEF_NUM_PORTS    = 5;
  localparam int DEF_DST_PORT_POS = 24;

  localparam logic [31:0] DROP_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FORWARD = 2'd1,
    ST_DROP    = 2'd2
  } state_e;

endpackage

// File: rtl/output_port_demux_out_reg.sv
// One-beat output register for a single demux port.
// Ports: clk/rst, load + beat in, m_* stream out, free status.
module demux_out_reg
  import output_port_demux_pkg::*;
#(
  parameter int DW = DEF_DATA_WIDTH,
  parameter int TW = DEF_TUSER_WIDTH
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] in_data,
  input  logic [DW/8-1:0] in_strb,
  input  logic [TW-1:0] in_user,
  input  logic          in_last,
  input  logic          m_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic [DW/8-1:0] m_strb,
  output logic [TW-1:0] m_user,
  output logic          m_last,
  output logic          free
);

  logic            valid_q, valid_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW/8-1:0] strb_q, strb_d;
  logic [TW-1:0]   user_q, user_d;
  logic            last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    if (valid_q && m_ready) valid_d = 1'b0;
    // a load wins over a drain in the same cycle
    if (load) valid_d = 1'b1;
    data_d = load ? in_data : data_q;
    strb_d = load ? in_strb : strb_q;
    user_d = load ? in_user : user_q;
    last_d = load ? in_last : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    strb_q <= strb_d;
    user_q <= user_d;
    last_q <= last_d;
  end

  // masked while reset is high so nothing stale shows on the bus
  assign m_valid = valid_q & ~rst;
  assign m_data  = data_q;
  assign m_strb  = strb_q;
  assign m_user  = user_q;
  assign m_last  = last_q;
  assign free    = ~valid_q | m_ready;

endmodule

// File: rtl/output_port_demux.sv
// Routes packets from one AXI4-Stream slave to one-hot selected ports.
// Ports: s_axis_* in, m_axis_* (NUM_PORTS slices) out, drop_count.
module output_port_demux
  import output_port_demux_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int C_S_AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH,
  parameter int NUM_PORTS            = DEF_NUM_PORTS,
  parameter int DST_PORT_POS         = DEF_DST_PORT_POS
)(
  input  logic axi_aclk,
  input  logic axi_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic [NUM_PORTS-1:0]              m_axis_tvalid,
  input  logic [NUM_PORTS-1:0]              m_axis_tready,
  output logic [NUM_PORTS-1:0]              m_axis_tlast,
  output logic [31:0]                       drop_count
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int TW = C_S_AXIS_TUSER_WIDTH;
  localparam int NP = NUM_PORTS;

  state_e          state_q, state_d;
  logic [NP-1:0]   dst_q, dst_d;
  logic [31:0]     drop_q, drop_d;
  logic [NP-1:0]   dst_in, sel, free, load;
  logic            all_free, tready, accept;

  assign dst_in = s_axis_tuser[DST_PORT_POS +: NP];

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q <= ST_IDLE;
      dst_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    drop_d  = drop_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (dst_in == '0) begin
            if (drop_q != DROP_MAX) drop_d = drop_q + 32'd1;
            if (!s_axis_tlast) state_d = ST_DROP;
          end else begin
            dst_d = dst_in;
            if (!s_axis_tlast) state_d = ST_FORWARD;
          end
        end
      end
      ST_FORWARD, ST_DROP: begin
        if (accept && s_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // first beat routes by its own tuser, later beats by dst_q
  always_comb begin
    sel = '0;
    unique case (state_q)
      ST_IDLE:    sel = dst_in;
      ST_FORWARD: sel = dst_q;
      default:    sel = '0;
    endcase
    // all selected ports must take the beat together
    all_free = &(free | ~sel);
    tready   = ~axi_reset & ((state_q == ST_DROP) | all_free);
    accept   = s_axis_tvalid & tready;
    load     = accept ? sel : '0;
  end

  assign s_axis_tready = tready;
  assign drop_count    = drop_q;

  for (genvar i = 0; i < NP; i++) begin : g_port
    demux_out_reg #(
      .DW(DW),
      .TW(TW)
    ) u_reg (
      .clk     (axi_aclk),
      .rst     (axi_reset),
      .load    (load[i]),
      .in_data (s_axis_tdata),
      .in_strb (s_axis_tstrb),
      .in_user (s_axis_tuser),
      .in_last (s_axis_tlast),
      .m_ready (m_axis_tready[i]),
      .m_valid (m_axis_tvalid[i]),
      .m_data  (m_axis_tdata[i*DW +: DW]),
      .m_strb  (m_axis_tstrb[i*SW +: SW]),
      .m_user  (m_axis_tuser[i*TW +: TW]),
      .m_last  (m_axis_tlast[i]),
      .free    (free[i])
    );
  end

endmodule

// File: tb/tb_output_port_demux.sv
// Self-checking bench for output_port_demux.
// Directed cases plus random traffic against a packet-level model.
module tb_output_port_demux;

  localparam int DW  = 256;
  localparam int SW  = DW / 8;
  localparam int TW  = 128;
  localparam int NP  = 5;
  localparam int POS = 24;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [TW-1:0] user;
    logic          last;
  } beat_t;

  logic              axi_aclk;
  logic              axi_reset;
  logic [DW-1:0]     s_tdata;
  logic [SW-1:0]     s_tstrb;
  logic [TW-1:0]     s_tuser;
  logic              s_tvalid;
  logic              s_tready;
  logic              s_tlast;
  logic [NP*DW-1:0]  m_tdata;
  logic [NP*SW-1:0]  m_tstrb;
  logic [NP*TW-1:0]  m_tuser;
  logic [NP-1:0]     m_tvalid;
  logic [NP-1:0]     m_tready;
  logic [NP-1:0]     m_tlast;
  logic [31:0]       drop_count;

  int tests = 0;
  int fails = 0;

  beat_t       q[NP][$];
  logic [31:0] mdrop = 0;
  bit          in_fwd = 0;
  bit          in_drop = 0;
  logic [NP-1:0] mdst = '0;

  bit rand_rdy = 0;
  int waited;

  output_port_demux dut (
    .axi_aclk      (axi_aclk),
    .axi_reset     (axi_reset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .drop_count    (drop_count)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] mk_user(input logic [NP-1:0] d);
    logic [TW-1:0] u;
    for (int k = 0; k < TW / 32; k++) u[k*32 +: 32] = $urandom;
    u[POS +: NP] = d;
    return u;
  endfunction

  function automatic beat_t port_beat(input int i);
    beat_t b;
    b.data = m_tdata[i*DW +: DW];
    b.strb = m_tstrb[i*SW +: SW];
    b.user = m_tuser[i*TW +: TW];
    b.last = m_tlast[i];
    return b;
  endfunction

  task automatic set_beat(input logic [TW-1:0] u, input logic last);
    for (int k = 0; k < DW / 32; k++) s_tdata[k*32 +: 32] = $urandom;
    s_tstrb = $urandom;
    s_tuser = u;
    s_tlast = last;
  endtask

  task automatic step();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) step();
  endtask

  // holds the current beat until accepted, bounded
  task automatic send_cur();
    bit ok;
    ok = 0;
    waited = 0;
    s_tvalid = 1'b1;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge axi_aclk);
      ok = s_tready;
      step();
      if (rand_rdy) m_tready = NP'($urandom);
      if (!ok) waited++;
    end
    s_tvalid = 1'b0;
    chk("handshake", 512'(ok), 512'(1));
  endtask

  task automatic send(input logic [NP-1:0] d, input logic last);
    set_beat(mk_user(d), last);
    send_cur();
  endtask

  // packet-level model: routing fixed by the first beat of each packet
  task automatic model_accept();
    beat_t b;
    logic [NP-1:0] route;
    b = '{s_tdata, s_tstrb, s_tuser, s_tlast};
    if (!in_fwd && !in_drop) begin
      route = s_tuser[POS +: NP];
      if (route == '0) begin
        if (mdrop != 32'hFFFF_FFFF) mdrop = mdrop + 1;
        in_drop = !s_tlast;
      end else begin
        mdst = route;
        in_fwd = !s_tlast;
      end
    end else if (in_drop) begin
      route = '0;
      if (s_tlast) in_drop = 0;
    end else begin
      route = mdst;
      if (s_tlast) in_fwd = 0;
    end
    for (int i = 0; i < NP; i++)
      if (route[i]) q[i].push_back(b);
  endtask

  initial begin : monitor
    forever begin
      @(negedge axi_aclk);
      if (axi_reset) begin
        for (int i = 0; i < NP; i++) q[i].delete();
        mdrop = 0;
        in_fwd = 0;
        in_drop = 0;
      end else begin
        for (int i = 0; i < NP; i++) begin
          if (m_tvalid[i] && m_tready[i]) begin
            chk($sformatf("port%0d_expected", i),
                512'(q[i].size() > 0), 512'(1));
            if (q[i].size() > 0)
              chk($sformatf("port%0d_beat", i),
                  512'(port_beat(i)), 512'(q[i].pop_front()));
          end
        end
        chk("drop_count", 512'(drop_count), 512'(mdrop));
        if (s_tvalid && s_tready) model_accept();
      end
    end
  end

  initial begin : stim
    axi_reset = 1'b1;
    s_tvalid  = 1'b0;
    s_tdata   = '0;
    s_tstrb   = '0;
    s_tuser   = '0;
    s_tlast   = 1'b0;
    m_tready  = '1;
    repeat (3) step();
    @(negedge axi_aclk);
    chk("rst_tready", 512'(s_tready), 512'(0));
    chk("rst_tvalid", 512'(m_tvalid), 512'(0));
    step();
    axi_reset = 1'b0;
    step();
    chk("post_rst_tvalid", 512'(m_tvalid), 512'(0));
    chk("post_rst_drop", 512'(drop_count), 512'(0));

    // 4-beat unicast to port 2, full rate
    for (int b = 0; b < 4; b++) begin
      send(5'b00100, b == 3);
      chk("uc_latency", 512'(m_tvalid), 512'(5'b00100));
      if (b > 0) chk("uc_b2b", 512'(waited), 512'(0));
    end
    chk("uc_tlast", 512'(m_tlast[2]), 512'(1));
    idle(1);
    chk("uc_done", 512'(m_tvalid), 512'(0));
    idle(2);

    // multicast stall on port 4
    send(5'b10001, 1'b0);
    chk("mc_first", 512'(m_tvalid), 512'(5'b10001));
    m_tready = 5'b01111;
    set_beat(mk_user(5'b00110), 1'b1);
    s_tvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge axi_aclk);
      chk("mc_stall_tready", 512'(s_tready), 512'(0));
      if (c > 0) chk("mc_no_partial", 512'(m_tvalid), 512'(5'b10000));
      step();
    end
    m_tready = '1;
    send_cur();
    chk("mc_second", 512'(m_tvalid), 512'(5'b10001));
    chk("mc_same", 512'(port_beat(0)), 512'(port_beat(4)));
    idle(3);

    // dropped 3-beat packet then single beat to port 1
    for (int b = 0; b < 3; b++) begin
      send(b == 0 ? 5'b00000 : 5'b11111, b == 2);
      chk("drop_no_leak", 512'(m_tvalid), 512'(0));
    end
    send(5'b00010, 1'b1);
    chk("drop_then_uc", 512'(m_tvalid), 512'(5'b00010));
    chk("drop_count_1", 512'(drop_count), 512'(1));
    idle(3);

    // mid-packet tuser must not reroute
    send(5'b00001, 1'b0);
    send(5'b01000, 1'b0);
    chk("midpkt_route", 512'(m_tvalid), 512'(5'b00001));
    send(5'b00000, 1'b1);
    chk("midpkt_last", 512'(m_tvalid), 512'(5'b00001));
    idle(3);

    // reset in the middle of a 5-beat packet with a beat buffered
    send(5'b00100, 1'b0);
    send(5'b00100, 1'b0);
    m_tready = 5'b11011;
    chk("rst_mid_buffered", 512'(m_tvalid), 512'(5'b00100));
    axi_reset = 1'b1;
    @(negedge axi_aclk);
    chk("rst_mid_tready", 512'(s_tready), 512'(0));
    chk("rst_mid_tvalid", 512'(m_tvalid), 512'(0));
    step();
    axi_reset = 1'b0;
    m_tready = '1;
    chk("rst_mid_after", 512'(m_tvalid), 512'(0));
    chk("rst_mid_drop", 512'(drop_count), 512'(0));
    send(5'b01000, 1'b1);
    chk("rst_mid_newpkt", 512'(m_tvalid), 512'(5'b01000));
    idle(3);

    // random traffic with random backpressure
    rand_rdy = 1;
    for (int p = 0; p < 200; p++) begin
      logic [NP-1:0] d;
      int len;
      len = $urandom_range(1, 4);
      d = ($urandom_range(0, 3) == 0) ? '0 : NP'($urandom_range(1, 31));
      for (int b = 0; b < len; b++)
        send(b == 0 ? d : NP'($urandom), b == len - 1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_rdy = 0;
    m_tready = '1;
    idle(10);
    for (int i = 0; i < NP; i++)
      chk($sformatf("drain%0d", i), 512'(q[i].size()), 512'(0));
    chk("final_idle", 512'(m_tvalid), 512'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
